// File: rtl/chunked_adder_scheduler.sv
// Round-robin scheduler that time-shares one external CHUNK-bit adder among NREQ
// requesters, running each WIDTH-bit add LSB-chunk first with a registered carry.
`timescale 1ns/1ps
module chunked_adder_scheduler #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 12,
    parameter int CHUNK = 3,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH:0]        rsp_sum,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy,
    output logic [CHUNK-1:0]      add_a,
    output logic [CHUNK-1:0]      add_b,
    output logic                  add_cin,
    input  logic [CHUNK-1:0]      add_sum,
    input  logic                  add_cout
);
    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [IDW-1:0]    last;
    logic [IDW-1:0]    id_q;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [WIDTH:0]    sum_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;

    logic              found;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    cand;

    // Search starts just after the previous winner, so every requester gets a turn.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && found)
            req_ready = NREQ'(1) << grant_idx;
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign add_a     = (state == RUN) ? a_q[int'(idx)*CHUNK +: CHUNK] : '0;
    assign add_b     = (state == RUN) ? b_q[int'(idx)*CHUNK +: CHUNK] : '0;
    assign add_cin   = (state == RUN) ? carry : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= IDW'(NREQ - 1);
            id_q  <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        id_q  <= grant_idx;
                        last  <= grant_idx;
                        idx   <= '0;
                        carry <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[int'(idx)*CHUNK +: CHUNK] <= add_sum;
                    carry <= add_cout;
                    idx   <= idx + IDXW'(1);
                    if (idx == IDXW'(NCH - 1)) begin
                        sum_q[WIDTH] <= add_cout;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operands are only consumed in RUN, which always follows a capture.
    always_ff @(posedge clk) begin
        if (state == IDLE && found) begin
            a_q <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
            b_q <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
        end
    end
endmodule

// File: tb/tb_chunked_adder_scheduler.sv
// Bench for chunked_adder_scheduler: directed and random adds checked against a
// round-robin / integer-addition reference, with a behavioural external chunk adder.
`timescale 1ns/1ps
module tb_chunked_adder_scheduler;
    localparam int NREQ  = 2;
    localparam int WIDTH = 12;
    localparam int CHUNK = 3;
    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDW   = 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH:0]        rsp_sum;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;
    logic [CHUNK-1:0]      add_a;
    logic [CHUNK-1:0]      add_b;
    logic                  add_cin;
    logic [CHUNK-1:0]      add_sum;
    logic                  add_cout;

    int vectors     = 0;
    int miscompares = 0;
    int mlast       = NREQ - 1;
    logic [WIDTH-1:0] cur_a [NREQ];
    logic [WIDTH-1:0] cur_b [NREQ];

    chunked_adder_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
    );

    // Golden external adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{CHUNK{1'b0}}, add_cin};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = cur_a[i];
            req_b[i*WIDTH +: WIDTH] = cur_b[i];
        end
    endtask

    task automatic chk_quiet_adder(input string tag);
        chk({tag, "_add_a"}, 32'(add_a), 32'd0);
        chk({tag, "_add_b"}, 32'(add_b), 32'd0);
        chk({tag, "_add_cin"}, 32'(add_cin), 32'd0);
    endtask

    // Entered and left just after a falling edge, while inputs may still change.
    task automatic issue(input logic [NREQ-1:0] vmask, input int hold,
                         input logic [NREQ-1:0] rmask, input logic [NREQ-1:0] dmask);
        int g;
        int w;
        logic [WIDTH-1:0] ea, eb;
        logic [WIDTH:0]   es;
        int unsigned m, s;
        req_valid = vmask;
        drive_ops();
        #1;
        w = 0;
        while (req_ready == '0 && w < 20) begin
            @(negedge clk); #1; w++;
        end
        g = -1;
        for (int k = 1; k <= NREQ; k++)
            if (g < 0 && vmask[(mlast + k) % NREQ]) g = (mlast + k) % NREQ;
        chk("grant", 32'(req_ready), 32'(1) << g);
        if (req_ready == '0) return;
        ea = cur_a[g];
        eb = cur_b[g];
        es = {1'b0, ea} + {1'b0, eb};
        mlast = g;
        for (int c = 0; c < NCH; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_valid[g] = 1'b0;
                cur_a[g] = WIDTH'($urandom);
                cur_b[g] = WIDTH'($urandom);
                drive_ops();
            end
            if (c == 1) req_valid = req_valid | rmask;
            if (c == NCH - 1) req_valid = req_valid & ~dmask;
            #1;
            m = (32'd1 << (CHUNK * c)) - 32'd1;
            s = (32'(ea) & m) + (32'(eb) & m);
            chk("run_add_a", 32'(add_a), 32'(CHUNK'(ea >> (CHUNK * c))));
            chk("run_add_b", 32'(add_b), 32'(CHUNK'(eb >> (CHUNK * c))));
            chk("run_add_cin", 32'(add_cin), (s >> (CHUNK * c)) & 32'd1);
            chk("run_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("run_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk); #1;
        chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_sum", 32'(rsp_sum), 32'(es));
        chk("rsp_id", 32'(rsp_id), 32'(g));
        rsp_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_sum", 32'(rsp_sum), 32'(es));
            chk("hold_rsp_id", 32'(rsp_id), 32'(g));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk_quiet_adder("hold");
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            cur_a[i] = '0;
            cur_b[i] = '0;
        end
        drive_ops();
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk_quiet_adder("reset");
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Directed 1 and 2: carry ripple across chunks.
        cur_a[0] = 12'h0FF; cur_b[0] = 12'h001;
        issue(2'b01, 0, 2'b00, 2'b00);
        cur_a[1] = 12'hFFF; cur_b[1] = 12'hFFF;
        issue(2'b10, 0, 2'b00, 2'b00);

        // Directed 3: both requesters contending.
        for (int n = 0; n < 6; n++) issue(2'b11, 0, 2'b00, 2'b00);

        // Directed 4: consumer back-pressure.
        issue(2'b11, 10, 2'b00, 2'b00);

        // Random traffic.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                cur_a[i] = WIDTH'($urandom);
                cur_b[i] = WIDTH'($urandom);
            end
            issue(NREQ'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 2'b00, 2'b00);
        end

        // Directed 5: reset while the add is mid-flight.
        cur_a[0] = 12'h5A5; cur_b[0] = 12'h3C3;
        req_valid = 2'b01;
        drive_ops();
        #1;
        chk("t5_grant", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("t5_req_ready", 32'(req_ready), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("t5_rsp_id", 32'(rsp_id), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk_quiet_adder("t5");
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mlast = NREQ - 1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk); #1;
            chk("t5_no_stale_rsp", 32'(rsp_valid), 32'd0);
            chk("t5_idle_busy", 32'(busy), 32'd0);
        end
        issue(2'b11, 0, 2'b00, 2'b00);

        // Directed 6: req0 withdraws before it can be granted.
        issue(2'b10, 0, 2'b11, 2'b01);
        issue(2'b10, 0, 2'b00, 2'b00);

        req_valid = '0;
        @(negedge clk); #1;
        chk("final_idle_busy", 32'(busy), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
